fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 109 ++++++++++
 tb/tb_fetch_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: loads a program into instruction memory through
// a valid/ready loader port, then fetches sequentially into the IF/ID register
// with stall and branch redirect support, and stops on a halt encoding.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        running
);

    // DEPTH is expected to be a power of two so branch targets wrap with a mask
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] LAST_PC = 32'((DEPTH - 1) * 4);
    localparam logic [31:0] PC_MASK = 32'(DEPTH * 4 - 1);
    localparam logic [AW-1:0] LAST_WR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        HALT
    } state_t;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   pc;
    logic          ld_accept;
    logic          load_done;
    logic [31:0]   pc_inc;
    logic [31:0]   branch_pc;

    // Memory port ownership and next-pc candidates; reset blocks loader writes
    always_comb begin
        ld_ready   = (state == LOAD) && !reset;
        ld_accept  = ld_ready && ld_valid;
        imem_we    = ld_accept;
        imem_wdata = ld_data;
        imem_addr  = (state == LOAD) ? (32'(wr_ptr) << 2) : pc;
        load_done  = ld_accept && (ld_last || (wr_ptr == LAST_WR));
        pc_inc     = (pc == LAST_PC) ? 32'd0 : pc + 32'd4;
        branch_pc  = {branch_target[31:2], 2'b00} & PC_MASK;
    end

    // Sequencer FSM with registered fetch outputs; branch outranks stall
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD;
            wr_ptr   <= '0;
            pc       <= RESET_PC;
            if_pc    <= 32'd0;
            if_instr <= 32'd0;
            if_valid <= 1'b0;
            running  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (ld_accept) begin
                        wr_ptr <= wr_ptr + AW'(1);
                    end
                    if (load_done) begin
                        state   <= RUN;
                        running <= 1'b1;
                        pc      <= RESET_PC;
                    end
                end
                RUN: begin
                    if (branch_taken) begin
                        pc       <= branch_pc;
                        if_instr <= 32'd0;
                        if_valid <= 1'b0;
                    end else if (!stall) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        pc       <= pc_inc;
                        if (imem_rdata == HALT_WORD) begin
                            state   <= HALT;
                            running <= 1'b0;
                        end
                    end
                end
                HALT: begin
                    if_valid <= 1'b0;
                end
                default: begin
                    state   <= LOAD;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer with a behavioural
// program/pc model and a simple instruction memory attached to the port.
module tb_fetch_sequencer;

    localparam int          DEPTH     = 16;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    logic        clk;
    logic        reset;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        running;

    logic [31:0] mem [DEPTH];

    typedef enum {M_LOAD, M_RUN, M_HALT} mode_t;
    mode_t       mMode;
    int          mWr;
    logic [31:0] mPc;
    logic [31:0] mIfPc;
    logic [31:0] mIfInstr;
    logic        mIfValid;
    logic [31:0] prog [DEPTH];

    int checks;
    int passes;
    int writeCount;

    fetch_sequencer #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .HALT_WORD(HALT_WORD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_we      (imem_we),
        .imem_wdata   (imem_wdata),
        .imem_rdata   (imem_rdata),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_valid     (if_valid),
        .running      (running)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read instruction memory seen by the sequencer
    assign imem_rdata = mem[imem_addr[5:2]];

    // Memory write port driven by the sequencer
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr[5:2]] <= imem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock cycle: drive, check port decoding, advance model, check fetch outputs
    task automatic applyStimulus(input logic rst, input logic lv, input logic [31:0] ld,
                                 input logic ll, input logic st, input logic bt,
                                 input logic [31:0] tgt);
        logic        expWe;
        logic [31:0] w;
        reset = rst; ld_valid = lv; ld_data = ld; ld_last = ll;
        stall = st; branch_taken = bt; branch_target = tgt;
        #3;
        expWe = (mMode == M_LOAD) && !rst && lv;
        checkOutput("ld_ready", ld_ready, (mMode == M_LOAD) && !rst);
        checkOutput("imem_we", imem_we, expWe);
        if (expWe) begin
            checkOutput("wr_addr", imem_addr, mWr * 4);
            checkOutput("wr_data", imem_wdata, ld);
        end else if (mMode != M_LOAD) begin
            checkOutput("fetch_addr", imem_addr, mPc);
        end
        if (imem_we === 1'b1) writeCount++;
        @(posedge clk);
        if (rst) begin
            mMode = M_LOAD; mWr = 0; mPc = RESET_PC;
            mIfPc = 0; mIfInstr = 0; mIfValid = 0;
        end else begin
            case (mMode)
                M_LOAD: if (lv) begin
                    prog[mWr] = ld;
                    if (ll || mWr == DEPTH - 1) begin
                        mMode = M_RUN;
                        mPc = RESET_PC;
                    end
                    mWr = (mWr + 1) % DEPTH;
                end
                M_RUN: begin
                    if (bt) begin
                        mPc = (tgt - (tgt % 4)) % (DEPTH * 4);
                        mIfInstr = 0;
                        mIfValid = 0;
                    end else if (!st) begin
                        w = prog[(mPc / 4) % DEPTH];
                        mIfInstr = w;
                        mIfPc = mPc;
                        mIfValid = 1;
                        mPc = (mPc + 4) % (DEPTH * 4);
                        if (w == HALT_WORD) mMode = M_HALT;
                    end
                end
                default: mIfValid = 0;
            endcase
        end
        #1;
        checkOutput("if_valid", if_valid, mIfValid);
        checkOutput("running", running, mMode == M_RUN);
        if (mIfValid) begin
            checkOutput("if_pc", if_pc, mIfPc);
            checkOutput("if_instr", if_instr, mIfInstr);
        end else if (mMode != M_HALT) begin
            checkOutput("if_instr_bubble", if_instr, mIfInstr);
        end
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    endtask

    // Loads n words with random gaps; haltAt < 0 means no halt word
    task automatic loadProgram(input int n, input int haltAt, input logic useLast);
        logic [31:0] word;
        for (int i = 0; i < n; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--)
                applyStimulus(1'b0, 1'b0, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            word = (i == haltAt) ? HALT_WORD : ($urandom | 32'h1);
            applyStimulus(1'b0, 1'b1, word, useLast && (i == n - 1), 1'($urandom), 1'($urandom), $urandom);
        end
    endtask

    task automatic runCycles(input int n, input int stallPct, input int branchPct);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'($urandom), $urandom, 1'($urandom),
                          $urandom_range(0, 99) < stallPct, $urandom_range(0, 99) < branchPct,
                          32'($urandom_range(0, DEPTH * 8 - 1)));
    endtask

    initial begin
        checks = 0; passes = 0; writeCount = 0;
        reset = 1'b1; ld_valid = 0; ld_data = 0; ld_last = 0;
        stall = 0; branch_taken = 0; branch_target = 0;
        mMode = M_LOAD; mWr = 0; mPc = RESET_PC; mIfPc = 0; mIfInstr = 0; mIfValid = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom | 32'h1;
            prog[i] = mem[i];
        end

        doReset(2);
        checkOutput("reset_if_pc", if_pc, 32'h0);

        // Reset in the middle of a load restarts the write pointer
        loadProgram(3, -1, 1'b0);
        doReset(1);
        writeCount = 0;
        loadProgram(8, -1, 1'b1);
        checkOutput("load_write_count", writeCount, 8);

        // Sequential fetch, stall hold, branch during stall
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("seq_if_pc", if_pc, 32'h4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0);
            checkOutput("stall_if_pc", if_pc, 32'h4);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("after_stall_if_pc", if_pc, 32'h8);
        applyStimulus(0, 0, 0, 0, 1, 1, 32'h6);
        checkOutput("branch_bubble", if_valid, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("branch_if_pc", if_pc, 32'h4);

        runCycles(150, 25, 10);

        // Reset while stalled, then a full-depth load without ld_last
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        doReset(2);
        writeCount = 0;
        loadProgram(DEPTH, -1, 1'b0);
        checkOutput("full_write_count", writeCount, DEPTH);
        runCycles(40, 0, 0);
        runCycles(60, 20, 15);

        // Halt word at index 3
        doReset(1);
        loadProgram(8, 3, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("halt_if_pc", if_pc, 32'hC);
        checkOutput("halt_if_instr", if_instr, HALT_WORD);
        runCycles(20, 20, 30);
        checkOutput("halt_running", running, 1'b0);

        // Branch in the same cycle as the halt word wins
        doReset(1);
        loadProgram(8, 3, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h10);
        checkOutput("branch_over_halt", running, 1'b1);
        runCycles(40, 20, 15);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
